// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared FSM encoding and lane constants for arbitro_fifos
//
// Purpose: state encoding, lane count and lane index width used by the
// arbiter top and its round-robin selector.
// Ports: none (package).

package arbitro_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } estado_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
        lane_onehot = NUM_LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/selector_rr.sv
// rtl/selector_rr.sv - combinational round-robin lane selector
//
// Purpose: picks the first requesting lane searching from last_grant+1
// (modulo NUM_LANES); the lane granted last has lowest priority.
// Ports:
//   req_i         - per-lane request vector (bit i = lane i)
//   last_grant_i  - lane granted on the previous pop
//   grant_valid_o - at least one lane is requesting
//   grant_idx_o   - winning lane index (0 when no request)

module selector_rr
    import arbitro_pkg::*;
(
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [LANE_W-1:0]    last_grant_i,
    output logic                 grant_valid_o,
    output logic [LANE_W-1:0]    grant_idx_o
);

    logic [LANE_W-1:0] cand;

    // Walk candidates from the farthest (last_grant itself) to the nearest
    // (last_grant+1); the last match written is the nearest, so it wins.
    // The 2-bit addition wraps naturally, giving the modulo-4 search.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            cand = last_grant_i + LANE_W'(k);
            if (req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_fifos.sv
// rtl/arbitro_fifos.sv - round-robin arbiter draining four input FIFOs into one output FIFO
//
// Purpose: pops one word per cycle from the non-empty input FIFOs in
// round-robin order and pushes it, tagged with its lane, to the output FIFO
// one cycle later. Input FIFOs return read data the cycle after rd_enable.
// Errors (input FIFO error, or push into a full output FIFO) are sticky and
// stop further pops until reset.
// Optional feature: define ARB_CONTADORES_EN to add per-lane push counters.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   empty_fifo       - per-lane input FIFO empty flags
//   error_fifo       - per-lane input FIFO error flags
//   data_fifo        - per-lane read data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   almost_full_out  - output FIFO has at most one free slot
//   full_out         - output FIFO full
//   rd_enable        - per-lane pop strobe (one-hot or zero)
//   wr_enable_out    - push strobe to output FIFO
//   data_out         - word pushed
//   lane_out         - source lane of data_out
//   error            - sticky error flag
//   estado           - current FSM state
//   cnt_lane         - (ARB_CONTADORES_EN only) 8-bit saturating push count per lane

module arbitro_fifos #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_LANES  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LANES-1:0]            empty_fifo,
    input  logic [NUM_LANES-1:0]            error_fifo,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_fifo,
    input  logic                            almost_full_out,
    input  logic                            full_out,
    output logic [NUM_LANES-1:0]            rd_enable,
    output logic                            wr_enable_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [1:0]                      lane_out,
    output logic                            error,
    output logic [1:0]                      estado
`ifdef ARB_CONTADORES_EN
    ,
    output logic [8*NUM_LANES-1:0]          cnt_lane
`endif
);

    import arbitro_pkg::*;

    estado_t           state_q, state_d;
    logic [LANE_W-1:0] last_grant_q, last_grant_d;
    logic              push_q, push_d;
    logic [LANE_W-1:0] push_lane_q, push_lane_d;
    logic              error_q, error_d;

    logic              grant_valid;
    logic [LANE_W-1:0] grant_idx;
    logic              can_pop;
    logic              pop;
    logic              push_now;
    logic              err_event;

    selector_rr u_selector_rr (
        .req_i         (~empty_fifo),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // Outputs are forced to their reset values while reset is high, so a
    // word popped just before reset never reaches the output FIFO.
    assign push_now  = push_q & ~reset;
    assign can_pop   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE))
                       && !almost_full_out && !full_out && !reset;
    assign pop       = can_pop && grant_valid;
    assign err_event = (|error_fifo) || (full_out && push_now);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        push_d       = pop;
        push_lane_d  = grant_idx;
        error_d      = error_q | err_event;

        if (pop) begin
            last_grant_d = grant_idx;
        end

        if (err_event) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE,
                ST_ACTIVE: state_d = pop ? ST_ACTIVE : ST_IDLE;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            last_grant_q <= LANE_W'(NUM_LANES - 1);
            push_q       <= 1'b0;
            push_lane_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            push_q       <= push_d;
            push_lane_q  <= push_lane_d;
            error_q      <= error_d;
        end
    end

    assign rd_enable     = pop ? lane_onehot(grant_idx) : '0;
    assign wr_enable_out = push_now;
    assign lane_out      = push_now ? push_lane_q : 2'd0;
    // The source FIFO presents the popped word this cycle, so data is taken
    // straight from its read port rather than registered here.
    assign data_out      = push_now ? data_fifo[push_lane_q*DATA_WIDTH +: DATA_WIDTH]
                                    : '0;
    assign error         = error_q & ~reset;
    assign estado        = reset ? ST_INIT : state_q;

`ifdef ARB_CONTADORES_EN
    logic [NUM_LANES-1:0][7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (push_now && (cnt_q[push_lane_q] != 8'hFF)) begin
            cnt_q[push_lane_q] <= cnt_q[push_lane_q] + 8'd1;
        end
    end

    assign cnt_lane = cnt_q;
`endif

endmodule

// File: tb/tb_arbitro_fifos.sv
// tb/tb_arbitro_fifos.sv - directed self-checking bench for arbitro_fifos

module tb_arbitro_fifos;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    empty_fifo;
    logic [3:0]    error_fifo;
    logic [4*DW-1:0] data_fifo;
    logic          almost_full_out;
    logic          full_out;
    logic [3:0]    rd_enable;
    logic          wr_enable_out;
    logic [DW-1:0] data_out;
    logic [1:0]    lane_out;
    logic          error;
    logic [1:0]    estado;
`ifdef ARB_CONTADORES_EN
    logic [31:0]   cnt_lane;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arbitro_fifos #(.DATA_WIDTH(DW), .NUM_LANES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .empty_fifo      (empty_fifo),
        .error_fifo      (error_fifo),
        .data_fifo       (data_fifo),
        .almost_full_out (almost_full_out),
        .full_out        (full_out),
        .rd_enable       (rd_enable),
        .wr_enable_out   (wr_enable_out),
        .data_out        (data_out),
        .lane_out        (lane_out),
        .error           (error),
        .estado          (estado)
`ifdef ARB_CONTADORES_EN
        ,
        .cnt_lane        (cnt_lane)
`endif
    );

    // Input FIFO models: read data and empty flag update the cycle after rd_enable.
    logic [DW-1:0] mem [4][512];
    logic [8:0]    wr_ptr [4];
    logic [8:0]    rd_ptr [4];
    logic [DW-1:0] rdata [4];
    logic          fifo_rst;

    for (genvar i = 0; i < 4; i++) begin : g_fifo
        assign empty_fifo[i]          = (rd_ptr[i] == wr_ptr[i]);
        assign data_fifo[i*DW +: DW]  = rdata[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rst) begin
                rd_ptr[i] <= '0;
                rdata[i]  <= '0;
            end else if (rd_enable[i]) begin
                rdata[i]  <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 9'd1;
            end
        end
    end

    task automatic load(input int lane, input logic [DW-1:0] w);
        mem[lane][wr_ptr[lane]] = w;
        wr_ptr[lane] = wr_ptr[lane] + 9'd1;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset           = 1'b1;
        fifo_rst        = 1'b1;
        error_fifo      = 4'b0000;
        almost_full_out = 1'b0;
        full_out        = 1'b0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
        tick;
        tick;
        fifo_rst = 1'b0;
        reset    = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset           = 1'b1;
        fifo_rst        = 1'b1;
        error_fifo      = 4'b0000;
        almost_full_out = 1'b0;
        full_out        = 1'b0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
        tick;
        tick;
        fifo_rst = 1'b0;
        load(0, 6'h15);
        #1;
        total++; if (rd_enable !== 4'b0000) begin bad++; $display("FAIL reset_rd got %b want 0000", rd_enable); end
        total++; if (wr_enable_out !== 1'b0) begin bad++; $display("FAIL reset_wr got %b want 0", wr_enable_out); end
        total++; if (data_out !== 6'h00 || lane_out !== 2'd0) begin bad++; $display("FAIL reset_data got %h/%0d want 00/0", data_out, lane_out); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got %b want 0", error); end
        total++; if (estado !== 2'd0) begin bad++; $display("FAIL reset_estado got %0d want 0", estado); end
        reset = 1'b0;
        #1;
        total++; if (estado !== 2'd0 || rd_enable !== 4'b0000) begin bad++; $display("FAIL init_cycle estado=%0d rd=%b want 0/0000", estado, rd_enable); end
        tick; #1;
        total++; if (estado !== 2'd1 || rd_enable !== 4'b0001) begin bad++; $display("FAIL first_idle estado=%0d rd=%b want 1/0001", estado, rd_enable); end
        tick; #1;
        total++; if (wr_enable_out !== 1'b1 || lane_out !== 2'd0 || data_out !== 6'h15) begin bad++; $display("FAIL first_push wr=%b lane=%0d data=%h want 1/0/15", wr_enable_out, lane_out, data_out); end
        total++; if (estado !== 2'd2 || rd_enable !== 4'b0000) begin bad++; $display("FAIL first_active estado=%0d rd=%b want 2/0000", estado, rd_enable); end
        tick; #1;
        total++; if (estado !== 2'd1 || wr_enable_out !== 1'b0) begin bad++; $display("FAIL back_idle estado=%0d wr=%b want 1/0", estado, wr_enable_out); end
    endtask

    task automatic test_round_robin;
        logic [3:0] e_rd [6];
        logic       e_wr [6];
        logic [1:0] e_ln [6];
        logic [5:0] e_dt [6];
        logic [1:0] e_st [6];
        e_rd = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        e_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_ln = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        e_dt = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h00};
        e_st = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        do_reset;
        load(0, 6'h01); load(1, 6'h02); load(2, 6'h03); load(3, 6'h04);
        #1;
        total++; if (rd_enable !== 4'b0000) begin bad++; $display("FAIL rr_init_nopop got %b want 0000", rd_enable); end
        for (int c = 0; c < 6; c++) begin
            tick; #1;
            total++; if (rd_enable !== e_rd[c]) begin bad++; $display("FAIL rr_rd c%0d got %b want %b", c, rd_enable, e_rd[c]); end
            total++; if (wr_enable_out !== e_wr[c]) begin bad++; $display("FAIL rr_wr c%0d got %b want %b", c, wr_enable_out, e_wr[c]); end
            total++; if (estado !== e_st[c]) begin bad++; $display("FAIL rr_estado c%0d got %0d want %0d", c, estado, e_st[c]); end
            if (e_wr[c]) begin
                total++; if (lane_out !== e_ln[c] || data_out !== e_dt[c]) begin bad++; $display("FAIL rr_push c%0d got %0d/%h want %0d/%h", c, lane_out, data_out, e_ln[c], e_dt[c]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] e_rd [5];
        logic       e_wr [5];
        logic [5:0] e_dt [5];
        logic [1:0] e_st [5];
        e_rd = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        e_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_dt = '{6'h00, 6'h21, 6'h22, 6'h23, 6'h00};
        e_st = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
        do_reset;
        load(2, 6'h21); load(2, 6'h22); load(2, 6'h23);
        for (int c = 0; c < 5; c++) begin
            tick; #1;
            total++; if (rd_enable !== e_rd[c]) begin bad++; $display("FAIL b2b_rd c%0d got %b want %b", c, rd_enable, e_rd[c]); end
            total++; if (wr_enable_out !== e_wr[c]) begin bad++; $display("FAIL b2b_wr c%0d got %b want %b", c, wr_enable_out, e_wr[c]); end
            total++; if (estado !== e_st[c]) begin bad++; $display("FAIL b2b_estado c%0d got %0d want %0d", c, estado, e_st[c]); end
            if (e_wr[c]) begin
                total++; if (lane_out !== 2'd2 || data_out !== e_dt[c]) begin bad++; $display("FAIL b2b_push c%0d got %0d/%h want 2/%h", c, lane_out, data_out, e_dt[c]); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic       af   [12];
        logic [3:0] e_rd [12];
        logic       e_wr [12];
        logic [1:0] e_ln [12];
        logic [5:0] e_dt [12];
        logic [1:0] e_st [12];
        af   = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        e_rd = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        e_wr = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        e_ln = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        e_dt = '{6'h00, 6'h0A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h1C, 6'h2C, 6'h3C, 6'h0B, 6'h00};
        e_st = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        do_reset;
        load(0, 6'h0A); load(0, 6'h0B); load(1, 6'h1C); load(2, 6'h2C); load(3, 6'h3C);
        for (int c = 0; c < 12; c++) begin
            tick;
            almost_full_out = af[c];
            #1;
            total++; if (rd_enable !== e_rd[c]) begin bad++; $display("FAIL bp_rd c%0d got %b want %b", c, rd_enable, e_rd[c]); end
            total++; if (wr_enable_out !== e_wr[c]) begin bad++; $display("FAIL bp_wr c%0d got %b want %b", c, wr_enable_out, e_wr[c]); end
            total++; if (estado !== e_st[c]) begin bad++; $display("FAIL bp_estado c%0d got %0d want %0d", c, estado, e_st[c]); end
            if (e_wr[c]) begin
                total++; if (lane_out !== e_ln[c] || data_out !== e_dt[c]) begin bad++; $display("FAIL bp_push c%0d got %0d/%h want %0d/%h", c, lane_out, data_out, e_ln[c], e_dt[c]); end
            end
        end
        almost_full_out = 1'b0;
    endtask

    task automatic test_error;
        logic [3:0] ef   [8];
        logic [3:0] e_rd [8];
        logic       e_wr [8];
        logic [1:0] e_ln [8];
        logic [5:0] e_dt [8];
        logic [1:0] e_st [8];
        logic       e_er [8];
        ef   = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e_rd = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e_wr = '{0, 1, 1, 1, 1, 0, 0, 0};
        e_ln = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        e_dt = '{6'h00, 6'h10, 6'h18, 6'h11, 6'h19, 6'h00, 6'h00, 6'h00};
        e_st = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        e_er = '{0, 0, 0, 0, 1, 1, 1, 1};
        do_reset;
        for (int k = 0; k < 4; k++) begin
            load(0, 6'h10 + 6'(k));
            load(1, 6'h18 + 6'(k));
        end
        for (int c = 0; c < 8; c++) begin
            tick;
            error_fifo = ef[c];
            #1;
            total++; if (rd_enable !== e_rd[c]) begin bad++; $display("FAIL err_rd c%0d got %b want %b", c, rd_enable, e_rd[c]); end
            total++; if (wr_enable_out !== e_wr[c]) begin bad++; $display("FAIL err_wr c%0d got %b want %b", c, wr_enable_out, e_wr[c]); end
            total++; if (estado !== e_st[c] || error !== e_er[c]) begin bad++; $display("FAIL err_state c%0d got %0d/%b want %0d/%b", c, estado, error, e_st[c], e_er[c]); end
            if (e_wr[c]) begin
                total++; if (lane_out !== e_ln[c] || data_out !== e_dt[c]) begin bad++; $display("FAIL err_push c%0d got %0d/%h want %0d/%h", c, lane_out, data_out, e_ln[c], e_dt[c]); end
            end
        end
        // Push into a full output FIFO is an error too.
        do_reset;
        load(0, 6'h05); load(1, 6'h06);
        tick; #1;
        total++; if (rd_enable !== 4'b0001) begin bad++; $display("FAIL full_pop got %b want 0001", rd_enable); end
        tick;
        full_out = 1'b1;
        #1;
        total++; if (rd_enable !== 4'b0000 || wr_enable_out !== 1'b1 || data_out !== 6'h05) begin bad++; $display("FAIL full_block rd=%b wr=%b data=%h want 0000/1/05", rd_enable, wr_enable_out, data_out); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL full_err_early got %b want 0", error); end
        tick;
        full_out = 1'b0;
        #1;
        total++; if (error !== 1'b1 || estado !== 2'd3 || rd_enable !== 4'b0000) begin bad++; $display("FAIL full_err err=%b estado=%0d rd=%b want 1/3/0000", error, estado, rd_enable); end
    endtask

    task automatic test_reset_midflight;
        logic       rs   [7];
        logic [3:0] e_rd [7];
        logic       e_wr [7];
        logic [1:0] e_ln [7];
        logic [5:0] e_dt [7];
        logic [1:0] e_st [7];
        rs   = '{0, 1, 1, 0, 0, 0, 0};
        e_rd = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        e_wr = '{0, 0, 0, 0, 0, 1, 1};
        e_ln = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        e_dt = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h2B, 6'h31};
        e_st = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        do_reset;
        load(0, 6'h2A); load(0, 6'h2B); load(1, 6'h31);
        for (int c = 0; c < 7; c++) begin
            tick;
            reset = rs[c];
            #1;
            total++; if (rd_enable !== e_rd[c]) begin bad++; $display("FAIL mid_rd c%0d got %b want %b", c, rd_enable, e_rd[c]); end
            total++; if (wr_enable_out !== e_wr[c]) begin bad++; $display("FAIL mid_wr c%0d got %b want %b", c, wr_enable_out, e_wr[c]); end
            total++; if (estado !== e_st[c] || error !== 1'b0) begin bad++; $display("FAIL mid_state c%0d got %0d/%b want %0d/0", c, estado, error, e_st[c]); end
            total++; if (lane_out !== e_ln[c] || data_out !== e_dt[c]) begin bad++; $display("FAIL mid_data c%0d got %0d/%h want %0d/%h", c, lane_out, data_out, e_ln[c], e_dt[c]); end
        end
        reset = 1'b0;
    endtask

`ifdef ARB_CONTADORES_EN
    task automatic test_counters;
        do_reset;
        for (int k = 0; k < 300; k++) load(3, 6'(k));
        for (int c = 0; c < 306; c++) begin
            tick; #1;
            if (c == 101) begin
                total++; if (cnt_lane !== {8'd100, 24'd0}) begin bad++; $display("FAIL cnt_mid got %h want 64000000", cnt_lane); end
            end
        end
        total++; if (cnt_lane !== {8'd255, 24'd0}) begin bad++; $display("FAIL cnt_sat got %h want ff000000", cnt_lane); end
        do_reset;
        total++; if (cnt_lane !== 32'd0) begin bad++; $display("FAIL cnt_clear got %h want 00000000", cnt_lane); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) wr_ptr[i] = '0;
        test_reset;
        test_round_robin;
        test_back_to_back;
        test_backpressure;
        test_error;
        test_reset_midflight;
`ifdef ARB_CONTADORES_EN
        test_counters;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
